// File: rtl/system_tick_servicer.sv
// ============================================================================
// Module   : system_tick_servicer
// Brief    : Services interval-timer interrupts, keeps a 32-bit tick count and
//            raises an alarm interrupt through a 16-bit Avalon-MM slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module system_tick_servicer #(
    parameter logic [2:0]  TIMER_STATUS_ADDR = 3'd0,
    parameter logic [31:0] RESET_ALARM       = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        timer_irq,
    output logic [2:0]  tmr_address,
    output logic        tmr_chipselect,
    output logic        tmr_write_n,
    output logic [15:0] tmr_writedata,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    localparam logic [2:0] c_addr_status  = 3'd0;
    localparam logic [2:0] c_addr_control = 3'd1;
    localparam logic [2:0] c_addr_tick_l  = 3'd2;
    localparam logic [2:0] c_addr_tick_h  = 3'd3;
    localparam logic [2:0] c_addr_alarm_l = 3'd4;
    localparam logic [2:0] c_addr_alarm_h = 3'd5;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_tick;
    logic [31:0] r_alarm;
    logic [2:0]  r_ctrl;        // {rearm, alarm_ie, cnt_en}
    logic        r_alarm_flag;
    logic [15:0] r_tick_h_snap;

    logic        w_wr;
    logic        w_rd;
    logic        w_inc;
    logic [31:0] w_tick_inc;
    logic        w_match;
    logic [2:0]  w_ctrl_nxt;
    logic        w_flag_nxt;
    logic [15:0] w_rd_mux;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = 3'd0;
        case (r_state)
            ST_IDLE: begin
                if (timer_irq) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = TIMER_STATUS_ADDR;
                w_state_nxt    = ST_SETTLE;
            end
            // The timer needs one more cycle to drop its irq after the write.
            ST_SETTLE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign tmr_writedata = 16'h0000;

    assign w_wr       = chipselect & ~write_n;
    assign w_rd       = chipselect & write_n;
    assign w_inc      = (r_state == ST_IDLE) & timer_irq & r_ctrl[0];
    assign w_tick_inc = r_tick + 32'd1;
    assign w_match    = w_inc & (w_tick_inc == r_alarm);

    // One-shot auto-clear of cnt_en overrides a same-edge CPU write of that bit.
    always_comb begin
        w_ctrl_nxt = r_ctrl;
        if (w_wr && (address == c_addr_control)) begin
            w_ctrl_nxt = writedata[2:0];
        end
        if (w_match && !r_ctrl[2]) begin
            w_ctrl_nxt[0] = 1'b0;
        end
    end

    always_comb begin
        w_flag_nxt = r_alarm_flag;
        if (w_wr && (address == c_addr_status)) begin
            w_flag_nxt = 1'b0;
        end
        if (w_match) begin
            w_flag_nxt = 1'b1;
        end
    end

    always_comb begin
        w_rd_mux = 16'h0000;
        case (address)
            c_addr_status:  w_rd_mux = {13'b0, r_ctrl[0], (r_state != ST_IDLE), r_alarm_flag};
            c_addr_control: w_rd_mux = {13'b0, r_ctrl};
            c_addr_tick_l:  w_rd_mux = r_tick[15:0];
            c_addr_tick_h:  w_rd_mux = r_tick_h_snap;
            c_addr_alarm_l: w_rd_mux = r_alarm[15:0];
            c_addr_alarm_h: w_rd_mux = r_alarm[31:16];
            default:        w_rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick        <= 32'd0;
            r_alarm       <= RESET_ALARM;
            r_ctrl        <= 3'd0;
            r_alarm_flag  <= 1'b0;
            r_tick_h_snap <= 16'h0000;
            readdata      <= 16'h0000;
            irq           <= 1'b0;
        end else begin
            if (w_wr && (address == c_addr_tick_l)) begin
                r_tick <= 32'd0;
            end else if (w_inc) begin
                r_tick <= w_tick_inc;
            end
            if (w_wr && (address == c_addr_alarm_l)) begin
                r_alarm[15:0] <= writedata;
            end
            if (w_wr && (address == c_addr_alarm_h)) begin
                r_alarm[31:16] <= writedata;
            end
            // Snapshot pairs with the low half returned on this same edge.
            if (w_rd && (address == c_addr_tick_l)) begin
                r_tick_h_snap <= r_tick[31:16];
            end
            r_ctrl       <= w_ctrl_nxt;
            r_alarm_flag <= w_flag_nxt;
            readdata     <= w_rd_mux;
            irq          <= w_flag_nxt & w_ctrl_nxt[1];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_system_tick_servicer.sv
// ============================================================================
// Module   : tb_system_tick_servicer
// Brief    : Directed and randomized bench for system_tick_servicer against a
//            cycle-level behavioural model of the tick/alarm register rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_system_tick_servicer;

    localparam logic [31:0] RESET_ALARM = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        timer_irq;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    always #5 clk = ~clk;

    system_tick_servicer #(
        .TIMER_STATUS_ADDR (3'd0),
        .RESET_ALARM       (RESET_ALARM)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .timer_irq      (timer_irq),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .address        (address),
        .chipselect     (chipselect),
        .write_n        (write_n),
        .writedata      (writedata),
        .readdata       (readdata),
        .irq            (irq)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state; m_busy counts remaining service cycles (2 = writing the timer).
    logic [31:0] m_tick;
    logic [31:0] m_alarm;
    logic [2:0]  m_ctrl;
    logic        m_flag;
    logic [15:0] m_snap;
    logic [15:0] m_rd;
    logic        m_irq;
    int          m_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_mux(input logic [2:0] a);
        case (a)
            3'd0:    return {13'b0, m_ctrl[0], (m_busy != 0), m_flag};
            3'd1:    return {13'b0, m_ctrl};
            3'd2:    return m_tick[15:0];
            3'd3:    return m_snap;
            3'd4:    return m_alarm[15:0];
            3'd5:    return m_alarm[31:16];
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_update(input logic rst, input logic tirq, input logic [2:0] a,
                                input logic cs, input logic wn, input logic [15:0] d);
        logic [15:0] rdv;
        logic [31:0] nt;
        logic        svc, inc, match, wr, rd, rearm_old;
        if (rst) begin
            m_tick  = 32'd0;
            m_alarm = RESET_ALARM;
            m_ctrl  = 3'd0;
            m_flag  = 1'b0;
            m_snap  = 16'h0;
            m_busy  = 0;
            m_rd    = 16'h0;
            m_irq   = 1'b0;
        end else begin
            rdv   = model_mux(a);
            svc   = (m_busy == 0) && tirq;
            inc   = svc && m_ctrl[0];
            nt    = m_tick + 32'd1;
            match = inc && (nt == m_alarm);
            wr    = cs && !wn;
            rd    = cs && wn;
            if (rd && a == 3'd2) m_snap = m_tick[31:16];
            if (wr && a == 3'd2) m_tick = 32'd0;
            else if (inc)        m_tick = nt;
            if (wr && a == 3'd4) m_alarm[15:0]  = d;
            if (wr && a == 3'd5) m_alarm[31:16] = d;
            rearm_old = m_ctrl[2];
            if (wr && a == 3'd1) m_ctrl = d[2:0];
            if (match && !rearm_old) m_ctrl[0] = 1'b0;
            if (wr && a == 3'd0) m_flag = 1'b0;
            if (match) m_flag = 1'b1;
            m_busy = svc ? 2 : ((m_busy > 0) ? m_busy - 1 : 0);
            m_rd   = rdv;
            m_irq  = m_flag & m_ctrl[1];
        end
    endtask

    // One clock: model consumes the pre-edge inputs, outputs are checked 1 ns later.
    // The timer drops its irq after seeing the status write, unless it was in reset too.
    task automatic step();
        logic        rst_s, irq_s, cs_s, wn_s, tw;
        logic [2:0]  a_s;
        logic [15:0] d_s;
        rst_s = reset; irq_s = timer_irq; cs_s = chipselect; wn_s = write_n;
        a_s = address; d_s = writedata;
        tw = tmr_chipselect && !tmr_write_n && (tmr_address == 3'd0);
        @(posedge clk);
        model_update(rst_s, irq_s, a_s, cs_s, wn_s, d_s);
        #1;
        if (tw && !rst_s) timer_irq = 1'b0;
        check("tmr_cs", {31'b0, tmr_chipselect}, {31'b0, (m_busy == 2)});
        check("tmr_wn", {31'b0, tmr_write_n}, {31'b0, (m_busy != 2)});
        if (m_busy == 2) check("tmr_addr", {29'b0, tmr_address}, 32'd0);
        check("tmr_wd", {16'b0, tmr_writedata}, 32'd0);
        check("readdata", {16'b0, readdata}, {16'b0, m_rd});
        check("irq", {31'b0, irq}, {31'b0, m_irq});
    endtask

    task automatic idle(input int n);
        chipselect = 1'b0;
        write_n    = 1'b1;
        repeat (n) step();
    endtask

    task automatic cpu_wr(input logic [2:0] a, input logic [15:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic cpu_rd(input logic [2:0] a);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        step();
        chipselect = 1'b0;
    endtask

    task automatic timer_tick();
        timer_irq = 1'b1;
        step();
        check("svc_wr", {31'b0, tmr_chipselect & ~tmr_write_n}, 32'd1);
        step();
        step();
    endtask

    task automatic preload(input logic [31:0] v);
        force dut.r_tick = v;
        #1;
        release dut.r_tick;
        m_tick = v;
    endtask

    initial begin
        reset = 1'b1; timer_irq = 1'b0; address = 3'd0;
        chipselect = 1'b0; write_n = 1'b1; writedata = 16'h0;

        step(); step();
        check("rst_rd", {16'b0, readdata}, 32'd0);
        check("rst_cs", {31'b0, tmr_chipselect}, 32'd0);
        reset = 1'b0;

        // First service with a STATUS read running to watch busy.
        cpu_wr(3'd1, 16'h0005);
        timer_irq = 1'b1; address = 3'd0; chipselect = 1'b1; write_n = 1'b1;
        step();
        check("first_svc", {31'b0, tmr_chipselect}, 32'd1);
        step();
        check("busy_1", {31'b0, readdata[1]}, 32'd1);
        step();
        check("busy_2", {31'b0, readdata[1]}, 32'd1);
        chipselect = 1'b0;
        cpu_rd(3'd2);
        check("tick_one", {16'b0, readdata}, 32'd1);

        // One-shot alarm at 3.
        cpu_wr(3'd2, 16'h0);
        cpu_wr(3'd4, 16'h0003);
        cpu_wr(3'd5, 16'h0000);
        cpu_wr(3'd1, 16'h0003);
        repeat (3) timer_tick();
        idle(1);
        check("alarm_irq", {31'b0, irq}, 32'd1);
        cpu_rd(3'd1);
        check("oneshot_ctrl", {16'b0, readdata}, 32'h2);
        timer_tick();
        cpu_rd(3'd2);
        check("frozen_tick", {16'b0, readdata}, 32'd3);

        // Wrap to zero.
        cpu_wr(3'd1, 16'h0005);
        preload(32'hFFFF_FFFF);
        timer_tick();
        cpu_rd(3'd2);
        check("wrap_l", {16'b0, readdata}, 32'd0);
        cpu_rd(3'd3);
        check("wrap_h", {16'b0, readdata}, 32'd0);

        // Coherent read: TICK_L read on the same edge as the increment.
        preload(32'h0001_FFFF);
        timer_irq = 1'b1; address = 3'd2; chipselect = 1'b1; write_n = 1'b1;
        step();
        chipselect = 1'b0;
        check("snap_l", {16'b0, readdata}, 32'hFFFF);
        step(); step();
        cpu_rd(3'd3);
        check("snap_h", {16'b0, readdata}, 32'h1);
        cpu_rd(3'd2);
        check("after_inc_l", {16'b0, readdata}, 32'h0);

        // TICK_L write beats a same-edge increment.
        preload(32'd5);
        timer_irq = 1'b1; address = 3'd2; chipselect = 1'b1; write_n = 1'b0; writedata = 16'h1234;
        step();
        chipselect = 1'b0; write_n = 1'b1;
        step(); step();
        cpu_rd(3'd2);
        check("clr_wins", {16'b0, readdata}, 32'd0);

        // Alarm match beats a same-edge STATUS write.
        cpu_wr(3'd4, 16'h0001);
        cpu_wr(3'd5, 16'h0000);
        cpu_wr(3'd1, 16'h0007);
        cpu_wr(3'd0, 16'h0000);
        timer_irq = 1'b1; address = 3'd0; chipselect = 1'b1; write_n = 1'b0;
        step();
        chipselect = 1'b0; write_n = 1'b1;
        step(); step();
        cpu_rd(3'd0);
        check("set_wins", {31'b0, readdata[0]}, 32'd1);
        check("set_irq", {31'b0, irq}, 32'd1);

        // Reset during CLEAR, then the held irq is serviced once.
        timer_irq = 1'b1;
        step();
        reset = 1'b1;
        step();
        check("rst_idle", {31'b0, tmr_chipselect}, 32'd0);
        reset = 1'b0;
        step();
        check("post_rst_svc", {31'b0, tmr_chipselect}, 32'd1);
        step(); step();
        idle(4);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(299) == 0);
            if (!timer_irq && $urandom_range(2) == 0) timer_irq = 1'b1;
            chipselect = ($urandom_range(2) == 0);
            write_n    = $urandom_range(1);
            address    = 3'($urandom_range(7));
            writedata  = 16'($urandom);
            if (address == 3'd2 && !write_n && $urandom_range(3) != 0) write_n = 1'b1;
            if (address == 3'd4) writedata = 16'($urandom_range(23));
            if (address == 3'd5 && $urandom_range(7) != 0) writedata = 16'h0;
            if (address == 3'd1 && $urandom_range(1) == 0) writedata[0] = 1'b1;
            step();
        end
        reset = 1'b0;
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
